seg7_scan_ctrl: RTL and testbench

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

---
 rtl/seg7_scan_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Three-digit BCD up/down counter with debounced pushbuttons and a
// multiplexed 7-segment scan that has per-slot blanking and a frame snapshot.

module seg7_db #(
    parameter int DB_CYC = 262144
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic ev
);
    localparam int CW = $clog2(DB_CYC + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYC - 1);

    // sync holds the pressed level (button is active-low), so reset means released
    logic [1:0]    sync;
    logic          acc;
    logic [CW-1:0] cnt;
    logic          lvl;
    logic          hit;

    assign lvl = sync[1];
    assign hit = (lvl != acc) && (cnt == DB_LAST);
    assign ev  = hit && lvl;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= '0;
            acc  <= 1'b0;
            cnt  <= '0;
        end else begin
            sync <= {sync[0], ~btn};
            if (lvl == acc) begin
                cnt <= '0;
            end else if (hit) begin
                acc <= lvl;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module seg7_scan_ctrl #(
    parameter int SCAN_DIV  = 65536,
    parameter int BLANK_CYC = 256,
    parameter int DB_CYC    = 262144
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        up_btn,
    input  logic        dn_btn,
    input  logic        clr_btn,
    input  logic        inc,
    input  logic        lzb,
    output logic [2:0]  digit_sel,
    output logic [6:0]  seg,
    output logic [11:0] bcd,
    output logic        carry,
    output logic        borrow
);
    localparam int SW = $clog2(SCAN_DIV + 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] BLANK_L   = SW'(BLANK_CYC);

    typedef enum logic [1:0] {S_U, S_T, S_H} state_t;

    logic [2:0]    btn_n;
    logic [2:0]    ev;
    logic          up, dn;
    logic [11:0]   bcd_nxt;
    logic          cy_nxt, bw_nxt;
    state_t        state, state_nxt;
    logic [SW-1:0] slot_cnt;
    logic          slot_end;
    logic [11:0]   snap;

    assign btn_n = {clr_btn, dn_btn, up_btn};

    for (genvar g = 0; g < 3; g++) begin : gen_db
        seg7_db #(.DB_CYC(DB_CYC)) u_db (
            .clk (clk),
            .rst (rst),
            .btn (btn_n[g]),
            .ev  (ev[g])
        );
    end

    assign up = ev[0] | inc;
    assign dn = ev[1];

    always_comb begin
        bcd_nxt = bcd;
        cy_nxt  = 1'b0;
        bw_nxt  = 1'b0;
        if (ev[2]) begin
            bcd_nxt = '0;
        end else if (up && !dn) begin
            if (bcd[3:0] != 4'd9) bcd_nxt[3:0] = bcd[3:0] + 4'd1;
            else begin
                bcd_nxt[3:0] = 4'd0;
                if (bcd[7:4] != 4'd9) bcd_nxt[7:4] = bcd[7:4] + 4'd1;
                else begin
                    bcd_nxt[7:4] = 4'd0;
                    if (bcd[11:8] != 4'd9) bcd_nxt[11:8] = bcd[11:8] + 4'd1;
                    else begin
                        bcd_nxt[11:8] = 4'd0;
                        cy_nxt        = 1'b1;
                    end
                end
            end
        end else if (dn && !up) begin
            if (bcd[3:0] != 4'd0) bcd_nxt[3:0] = bcd[3:0] - 4'd1;
            else begin
                bcd_nxt[3:0] = 4'd9;
                if (bcd[7:4] != 4'd0) bcd_nxt[7:4] = bcd[7:4] - 4'd1;
                else begin
                    bcd_nxt[7:4] = 4'd9;
                    if (bcd[11:8] != 4'd0) bcd_nxt[11:8] = bcd[11:8] - 4'd1;
                    else begin
                        bcd_nxt[11:8] = 4'd9;
                        bw_nxt        = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcd    <= '0;
            carry  <= 1'b0;
            borrow <= 1'b0;
        end else begin
            bcd    <= bcd_nxt;
            carry  <= cy_nxt;
            borrow <= bw_nxt;
        end
    end

    assign slot_end = (slot_cnt == SLOT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_U;
            slot_cnt <= '0;
        end else begin
            state    <= state_nxt;
            slot_cnt <= slot_end ? '0 : slot_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (slot_end) begin
            case (state)
                S_U:     state_nxt = S_T;
                S_T:     state_nxt = S_H;
                default: state_nxt = S_U;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                              snap <= '0;
        else if (state == S_U && slot_cnt == '0) snap <= bcd;
    end

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'b0111111;
            4'd1:    glyph = 7'b0000110;
            4'd2:    glyph = 7'b1011011;
            4'd3:    glyph = 7'b1001111;
            4'd4:    glyph = 7'b1100110;
            4'd5:    glyph = 7'b1101101;
            4'd6:    glyph = 7'b1111101;
            4'd7:    glyph = 7'b0000111;
            4'd8:    glyph = 7'b1111111;
            4'd9:    glyph = 7'b1101111;
            default: glyph = 7'b0000000;
        endcase
    endfunction

    logic [2:0] onehot;
    logic [3:0] cur;
    logic       blank;
    logic       first;

    // On the snapshot-load cycle itself the register is still stale, so take bcd
    assign first = (state == S_U) && (slot_cnt == '0);

    always_comb begin
        onehot    = 3'b000;
        cur       = 4'd0;
        blank     = 1'b0;
        digit_sel = 3'b000;
        seg       = 7'b0000000;
        case (state)
            S_U: begin
                onehot = 3'b001;
                cur    = first ? bcd[3:0] : snap[3:0];
            end
            S_T: begin
                onehot = 3'b010;
                cur    = snap[7:4];
                blank  = lzb && (snap[11:8] == 4'd0) && (snap[7:4] == 4'd0);
            end
            S_H: begin
                onehot = 3'b100;
                cur    = snap[11:8];
                blank  = lzb && (snap[11:8] == 4'd0);
            end
            default: onehot = 3'b000;
        endcase
        if (slot_cnt >= BLANK_L) begin
            digit_sel = onehot;
            seg       = blank ? 7'b0000000 : glyph(cur);
        end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed + randomized bench for seg7_scan_ctrl: integer count model,
// time-indexed scan model and scheduled button events.

module tb_seg7_scan_ctrl;
    localparam int SD = 16, BC = 4, DB = 8, FRAME = 3 * SD;

    logic        clk = 1'b0, rst = 1'b0;
    logic        up_btn = 1'b1, dn_btn = 1'b1, clr_btn = 1'b1;
    logic        inc = 1'b0, lzb = 1'b0;
    logic [2:0]  digit_sel;
    logic [6:0]  seg;
    logic [11:0] bcd;
    logic        carry, borrow;

    seg7_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC), .DB_CYC(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .up_btn    (up_btn),
        .dn_btn    (dn_btn),
        .clr_btn   (clr_btn),
        .inc       (inc),
        .lzb       (lzb),
        .digit_sel (digit_sel),
        .seg       (seg),
        .bcd       (bcd),
        .carry     (carry),
        .borrow    (borrow)
    );

    always #5 clk = ~clk;

    logic [6:0] GLYPH [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                               7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

    int errors = 0, checks = 0;
    int t = 0, mdl = 0, snap = 0;
    bit ev_up = 0, ev_dn = 0, ev_clr = 0, exp_carry = 0, exp_borrow = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic check_rst();
        chk("rst_digit_sel", {29'd0, digit_sel}, 32'd0);
        chk("rst_seg", {25'd0, seg}, 32'd0);
        chk("rst_bcd", {20'd0, bcd}, 32'd0);
        chk("rst_carry", {31'd0, carry}, 32'd0);
        chk("rst_borrow", {31'd0, borrow}, 32'd0);
    endtask

    task automatic check_all();
        int slot, pos, dg;
        logic [2:0] es;
        logic [6:0] eg;
        bit blk;
        slot = (t / SD) % 3;
        pos  = t % SD;
        es = 3'b000;
        eg = 7'b0000000;
        if (pos >= BC) begin
            es = 3'(1 << slot);
            case (slot)
                0:       dg = snap % 10;
                1:       dg = (snap / 10) % 10;
                default: dg = snap / 100;
            endcase
            blk = lzb && ((slot == 2 && snap < 100) || (slot == 1 && snap < 10));
            eg  = blk ? 7'b0000000 : GLYPH[dg];
        end
        chk("digit_sel", {29'd0, digit_sel}, {29'd0, es});
        chk("seg", {25'd0, seg}, {25'd0, eg});
        chk("bcd", {20'd0, bcd}, 32'((mdl / 100) * 256 + ((mdl / 10) % 10) * 16 + mdl % 10));
        chk("carry", {31'd0, carry}, {31'd0, exp_carry});
        chk("borrow", {31'd0, borrow}, {31'd0, exp_borrow});
    endtask

    // Applies the counting rule to the inputs presented this cycle, then moves to the next cycle
    task automatic step();
        bit up, dn;
        int nxt;
        up = ev_up | inc;
        dn = ev_dn;
        nxt = mdl;
        exp_carry = 0;
        exp_borrow = 0;
        if (ev_clr) nxt = 0;
        else if (up && !dn) begin
            nxt = (mdl + 1) % 1000;
            exp_carry = (mdl == 999);
        end else if (dn && !up) begin
            nxt = (mdl + 999) % 1000;
            exp_borrow = (mdl == 0);
        end
        @(negedge clk);
        mdl = nxt;
        t++;
        if (t % FRAME == 0) snap = mdl;
        check_all();
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    // Clean press: event expected after the 2-flop sync plus DB_CYC stable cycles
    task automatic press(input bit u, input bit d, input bit c, input bit with_inc, input int extra);
        up_btn = ~u;
        dn_btn = ~d;
        clr_btn = ~c;
        steps(DB + 1);
        ev_up = u;
        ev_dn = d;
        ev_clr = c;
        inc = with_inc;
        step();
        ev_up = 0;
        ev_dn = 0;
        ev_clr = 0;
        inc = 0;
        steps(extra);
        up_btn = 1;
        dn_btn = 1;
        clr_btn = 1;
        steps(DB + 4);
    endtask

    task automatic inc_to(input int target);
        int guard;
        guard = 0;
        while (mdl != target && guard < 2000) begin
            inc = 1;
            step();
            inc = 0;
            steps($urandom_range(0, 1));
            guard++;
        end
        chk("inc_to_reached", 32'(mdl), 32'(target));
    endtask

    initial begin
        int bl [3] = '{3, 5, 7};
        repeat (3) @(negedge clk);
        check_rst();
        rst = 1;
        t = 0; mdl = 0; snap = 0;
        check_all();
        steps(FRAME);
        lzb = 1;
        steps(FRAME);

        // bounces shorter than the debounce window, then a real press
        foreach (bl[i]) begin
            up_btn = 0;
            steps(bl[i]);
            up_btn = 1;
            steps(3);
        end
        press(1, 0, 0, 0, 11);
        chk("bounce_single_inc", {20'd0, bcd}, 32'h001);

        for (int k = 0; k < 4; k++) begin
            lzb = 1'($urandom_range(0, 1));
            repeat (100) begin
                inc = ($urandom_range(0, 3) == 0);
                step();
            end
            inc = 0;
        end

        inc_to(999);
        inc = 1;
        step();
        inc = 0;
        chk("wrap_up_bcd", {20'd0, bcd}, 32'h000);
        chk("wrap_up_carry", {31'd0, carry}, 32'd1);
        step();
        chk("carry_one_cycle", {31'd0, carry}, 32'd0);

        press(0, 1, 0, 0, 5);
        chk("wrap_dn_bcd", {20'd0, bcd}, 32'h999);

        press(1, 1, 0, 1, 5);
        chk("up_dn_inc_hold", {20'd0, bcd}, 32'h999);
        press(0, 0, 1, 1, 5);
        chk("clr_over_inc", {20'd0, bcd}, 32'h000);

        lzb = 0;
        inc_to(457);
        begin
            int guard;
            guard = 0;
            while ((t % FRAME) != 40 && guard < FRAME) begin
                step();
                guard++;
            end
        end
        #2 rst = 0;
        #1 check_rst();
        repeat (2) @(negedge clk);
        check_rst();
        rst = 1;
        t = 0; mdl = 0; snap = 0;
        check_all();
        steps(FRAME + 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
